// File: rtl/ysyx_scoreboard_pkg.sv
// Shared ysyx scoreboard types and defaults: register index, pending-writer counter
// and the global in-flight writer limit.
`ifndef YSYX_REG_NUM
`define YSYX_REG_NUM 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_scoreboard_pkg;

    localparam int YSYX_CNT_W        = 2;
    localparam int YSYX_MAX_INFLIGHT = 4;

    typedef logic [`YSYX_REG_LEN-1:0] reg_idx_t;
    typedef logic [YSYX_CNT_W-1:0]    cnt_t;

endpackage

// File: rtl/ysyx_scoreboard_cnt.sv
// Saturating up/down pending-writer counter for one architectural register.
// An inc and dec in the same cycle cancel; clr wins over both.
module ysyx_scoreboard_cnt
    import ysyx_scoreboard_pkg::*;
#(
    parameter int CNT_W = YSYX_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign busy      = (cnt_q != '0);
    // A lone retire against an empty counter has no matching writer.
    assign underflow = dec && !inc && !clr && (cnt_q == '0);

endmodule

// File: rtl/ysyx_scoreboard.sv
// RAW scoreboard: per-register pending-writer counters, global in-flight limit,
// sticky error flag. Optional same-cycle bypass under YSYX_SCOREBOARD_BYPASS_EN.
module ysyx_scoreboard
    import ysyx_scoreboard_pkg::*;
#(
    parameter int REG_NUM      = `YSYX_REG_NUM,
    parameter int REG_LEN      = `YSYX_REG_LEN,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = YSYX_MAX_INFLIGHT,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [REG_LEN-1:0] rs1,
    input  logic [REG_LEN-1:0] rs2,
    input  logic               need_rs,
    output logic               hazard,
    input  logic               issue_valid,
    input  logic [REG_LEN-1:0] issue_rd,
    output logic               issue_stall,
    input  logic               wb_valid,
    input  logic [REG_LEN-1:0] wb_rd,
    input  logic               flush,
    output logic [REG_NUM-1:0] rf_table,
    output logic [IW-1:0]      inflight,
    output logic               err
);

    logic [CNT_W-1:0]   cnt [REG_NUM];
    logic [REG_NUM-1:0] busy_v;
    logic [REG_NUM-1:0] under_v;
    logic [REG_NUM-1:0] full_v;
    logic [REG_NUM-1:0] busy_eff;

    logic [IW-1:0] inflight_q;
    logic          err_q;
    logic          flush_shadow_q;

    logic issue_acc;
    logic wb_act;
    logic same_rd;
    logic infl_inc;
    logic infl_dec;
    logic infl_under;
    logic cnt_under;
    logic err_set;

    assign issue_stall = (inflight_q == IW'(MAX_INFLIGHT)) || full_v[issue_rd];
    assign issue_acc   = issue_valid && !issue_stall && (issue_rd != '0);
    // Flush squashes everything in flight, so a same-cycle writeback is dropped.
    assign wb_act      = wb_valid && (wb_rd != '0) && !flush;
    assign same_rd     = issue_acc && wb_act && (issue_rd == wb_rd);

    assign infl_inc   = issue_acc;
    assign infl_dec   = wb_act && (busy_v[wb_rd] || same_rd);
    assign infl_under = infl_dec && !infl_inc && (inflight_q == '0);
    assign cnt_under  = wb_act && under_v[wb_rd];
    assign err_set    = (cnt_under || infl_under) && !flush_shadow_q;

    for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
        ysyx_scoreboard_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (issue_acc && (issue_rd == REG_LEN'(i))),
            .dec      (wb_act && (wb_rd == REG_LEN'(i))),
            .clr      (flush),
            .cnt      (cnt[i]),
            .busy     (busy_v[i]),
            .underflow(under_v[i])
        );
        assign full_v[i] = &cnt[i];
    end

`ifdef YSYX_SCOREBOARD_BYPASS_EN
    // The last pending writer retiring this cycle forwards its value to decode.
    logic [REG_NUM-1:0] retire_v;
    for (genvar i = 0; i < REG_NUM; i++) begin : g_byp
        assign retire_v[i] = (cnt[i] == CNT_W'(1)) && wb_valid && (wb_rd == REG_LEN'(i));
    end
    assign busy_eff = busy_v & ~retire_v;
`else
    assign busy_eff = busy_v;
`endif

    assign hazard = need_rs && (busy_eff[rs1] || busy_eff[rs2]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight_q     <= '0;
            err_q          <= 1'b0;
            flush_shadow_q <= 1'b0;
        end else begin
            flush_shadow_q <= flush;
            if (flush) begin
                inflight_q <= '0;
            end else if (infl_inc && !infl_dec) begin
                inflight_q <= inflight_q + IW'(1);
            end else if (infl_dec && !infl_inc && (inflight_q != '0)) begin
                inflight_q <= inflight_q - IW'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rf_table = busy_v;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ysyx_scoreboard.sv
// Self-checking bench for ysyx_scoreboard: behavioural model feeds an expected
// queue each cycle; registered outputs are popped and compared after the edge.
module tb_ysyx_scoreboard;

    localparam int RN   = 32;
    localparam int RL   = 5;
    localparam int IW   = 3;
    localparam int MAXF = 4;
    localparam int W    = 1 + IW + RN;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [RL-1:0] rs1 = '0;
    logic [RL-1:0] rs2 = '0;
    logic          need_rs = 1'b0;
    logic          hazard;
    logic          issue_valid = 1'b0;
    logic [RL-1:0] issue_rd = '0;
    logic          issue_stall;
    logic          wb_valid = 1'b0;
    logic [RL-1:0] wb_rd = '0;
    logic          flush = 1'b0;
    logic [RN-1:0] rf_table;
    logic [IW-1:0] inflight;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    int   cnt_m [RN];
    int   infl_m;
    logic err_m;
    logic shadow_m;

    logic [W-1:0] exp_q[$];

    ysyx_scoreboard dut (
        .clock      (clock),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .need_rs    (need_rs),
        .hazard     (hazard),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_stall(issue_stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .rf_table   (rf_table),
        .inflight   (inflight),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [RN-1:0] table_m();
        logic [RN-1:0] t;
        for (int i = 0; i < RN; i++) t[i] = (cnt_m[i] != 0);
        return t;
    endfunction

    function automatic logic busy_m(input logic [RL-1:0] x);
        logic b;
        b = (cnt_m[x] != 0);
`ifdef YSYX_SCOREBOARD_BYPASS_EN
        if (cnt_m[x] == 1 && wb_valid && wb_rd == x) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < RN; i++) cnt_m[i] = 0;
        infl_m = 0;
    endtask

    // One clock of stimulus: combinational checks before the edge, state after.
    task automatic step(input logic iv, input logic [RL-1:0] ird,
                        input logic wv, input logic [RL-1:0] wrd, input logic fl);
        logic         stall_m;
        logic         acc;
        logic         wbok;
        logic [W-1:0] e;
        issue_valid = iv;
        issue_rd    = ird;
        wb_valid    = wv;
        wb_rd       = wrd;
        flush       = fl;
        #1;
        stall_m = (infl_m == MAXF) || (cnt_m[ird] == 3);
        check_eq("issue_stall", issue_stall, stall_m);
        check_eq("hazard", hazard, need_rs && (busy_m(rs1) || busy_m(rs2)));
        acc  = iv && !stall_m && (ird != 0);
        wbok = wv && (wrd != 0);
        if (fl) begin
            model_clear();
        end else if (acc && wbok && ird == wrd) begin
            // net zero change
        end else begin
            if (acc) begin
                cnt_m[ird]++;
                infl_m++;
            end
            if (wbok) begin
                if (cnt_m[wrd] == 0) begin
                    if (!shadow_m) err_m = 1'b1;
                end else begin
                    cnt_m[wrd]--;
                    infl_m--;
                end
            end
        end
        shadow_m = fl;
        exp_q.push_back({err_m, IW'(infl_m), table_m()});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_eq("err", err, e[W-1]);
        check_eq("inflight", inflight, e[W-2 -: IW]);
        check_eq("rf_table", rf_table, e[RN-1:0]);
    endtask

    initial begin
        model_clear();
        err_m    = 1'b0;
        shadow_m = 1'b0;

        // reset state
        need_rs = 1'b1;
        rs1     = 5'd5;
        rs2     = 5'd7;
        #3;
        check_eq("rst_rf_table", rf_table, '0);
        check_eq("rst_inflight", inflight, '0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_hazard", hazard, 1'b0);
        check_eq("rst_issue_stall", issue_stall, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // RAW hazard on x5 until the cycle after its writeback
        need_rs = 1'b0;
        step(1, 5'd5, 0, 5'd0, 0);
        rs1 = 5'd5; rs2 = 5'd0; need_rs = 1'b1;
        step(0, 5'd0, 0, 5'd0, 0);
        step(0, 5'd0, 1, 5'd5, 0);
        step(0, 5'd0, 0, 5'd0, 0);
        need_rs = 1'b0;

        // x0 is never tracked
        step(1, 5'd0, 0, 5'd0, 0);
        step(0, 5'd0, 1, 5'd0, 0);

        // in-flight limit
        for (int r = 1; r <= 4; r++) step(1, RL'(r), 0, 5'd0, 0);
        step(1, 5'd10, 0, 5'd0, 0);
        step(0, 5'd10, 1, 5'd2, 0);
        step(0, 5'd10, 0, 5'd0, 0);
        step(0, 5'd0, 1, 5'd1, 0);
        step(0, 5'd0, 1, 5'd3, 0);
        step(0, 5'd0, 1, 5'd4, 0);

        // per-register counter saturation on x7
        for (int k = 0; k < 4; k++) step(1, 5'd7, 0, 5'd0, 0);
        for (int k = 0; k < 3; k++) step(0, 5'd7, 1, 5'd7, 0);
        step(0, 5'd0, 0, 5'd0, 0);

        // same-rd issue+wb, then flush and a squashed writeback
        step(1, 5'd9, 0, 5'd0, 0);
        step(1, 5'd9, 1, 5'd9, 0);
        step(1, 5'd11, 0, 5'd0, 1);
        step(0, 5'd0, 1, 5'd9, 0);
        step(0, 5'd0, 0, 5'd0, 0);

        // underflow outside the flush shadow is sticky
        step(0, 5'd0, 1, 5'd3, 0);
        step(0, 5'd0, 0, 5'd0, 0);
        step(1, 5'd12, 0, 5'd0, 1);
        step(0, 5'd0, 0, 5'd0, 0);

        // same-cycle retire of x6 while decode reads it
        step(1, 5'd6, 0, 5'd0, 0);
        rs1 = 5'd6; rs2 = 5'd0; need_rs = 1'b1;
        step(0, 5'd0, 1, 5'd6, 0);
        step(0, 5'd0, 0, 5'd0, 0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            rs1     = RL'($urandom_range(0, 7));
            rs2     = RL'($urandom_range(0, 7));
            need_rs = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), RL'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), RL'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0));
        end

        // asynchronous reset mid-operation
        step(0, 5'd0, 0, 5'd0, 1);
        step(1, 5'd2, 0, 5'd0, 0);
        step(1, 5'd3, 0, 5'd0, 0);
        rs1 = 5'd2; rs2 = 5'd3; need_rs = 1'b1;
        issue_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_rf_table", rf_table, '0);
        check_eq("mid_rst_inflight", inflight, '0);
        check_eq("mid_rst_err", err, 1'b0);
        check_eq("mid_rst_hazard", hazard, 1'b0);
        model_clear();
        err_m    = 1'b0;
        shadow_m = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(0, 5'd0, 0, 5'd0, 0);
        step(1, 5'd2, 0, 5'd0, 0);
        step(0, 5'd0, 1, 5'd3, 0);
        step(0, 5'd0, 1, 5'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
